// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit adjust threshold/increment follow the shift-and-add-3 scheme.
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  localparam int BCD_W         = 4;
  localparam int ADJ_THRESHOLD = 5;
  localparam int ADJ_ADD       = 3;

  localparam logic [BCD_W-1:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bin_to_bcd_seq_adjust.sv
// bcd_digit_adjust: combinational "add 3 if >= 5" cell for one BCD digit.
// The add wraps in 4 bits; the carry is never needed for legal digits.
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= BCD_W'(ADJ_THRESHOLD))
              ? din + BCD_W'(ADJ_ADD)
              : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional build macro BIN_TO_BCD_SATURATE_EN: overflowed results read all nines.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int n_dig = 4,
  parameter int bin_w = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [bin_w-1:0]       bin,
  output logic                   busy,
  output logic                   done,
  output logic [n_dig*BCD_W-1:0] number,
  output logic                   overflow
);

  localparam int ACC_W = n_dig * BCD_W;
  localparam int CNT_W = (bin_w > 1) ? $clog2(bin_w) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [bin_w-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_nxt;
  logic               sticky;
  logic               sticky_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               last;

  for (genvar g = 0; g < n_dig; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (acc[g*BCD_W +: BCD_W]),
      .dout (acc_adj[g*BCD_W +: BCD_W])
    );
  end

  // Bit leaving the top digit means the value exceeds n_dig digits.
  assign acc_nxt    = {acc_adj[ACC_W-2:0], shreg[bin_w-1]};
  assign sticky_nxt = sticky | acc_adj[ACC_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    last = 1'b0;
    unique case (state)
      IDLE:    load = start;
      CONVERT: begin
        busy = 1'b1;
        last = (cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      shreg  <= bin;
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= CNT_W'(bin_w - 1);
    end else if (busy) begin
      shreg  <= shreg << 1;
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
      cnt    <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      number   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        overflow <= sticky_nxt;
`ifdef BIN_TO_BCD_SATURATE_EN
        number <= sticky_nxt ? {n_dig{BCD_NINE}} : acc_nxt;
`else
        number <= acc_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a timing model queues expected
// results on each accepted start and checks them when done pulses.
module tb_bin_to_bcd_seq;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    logic [N*4-1:0] num;
    logic           ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   bin = '0;
  logic           busy;
  logic           done;
  logic [N*4-1:0] number;
  logic           overflow;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;

  bin_to_bcd_seq #(.n_dig(N), .bin_w(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .number   (number),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input int unsigned b);
    exp_t        e;
    int unsigned lim;
    int unsigned r;
    lim = 1;
    for (int i = 0; i < N; i++) lim = lim * 10;
    r     = b % lim;
    e.ovf = (b >= lim);
    e.num = '0;
    for (int d = 0; d < N; d++) begin
      e.num[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BIN_TO_BCD_SATURATE_EN
    if (e.ovf) e.num = {N{4'h9}};
`endif
    return e;
  endfunction

  // Cycle model: accept in idle, done on the W-th edge after acceptance.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      sb.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        sb.push_back(expect_of(32'(bin)));
        m_busy = 1'b1;
        m_cnt  = W;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (m_done) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("number", 32'(number), 32'(e.num));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic convert(input logic [W-1:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    logic [W-1:0] vals [5];
    vals = '{16'd1234, 16'd9999, 16'd0, 16'd10000, 16'd65535};

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_number", 32'(number), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vals[i]) convert(vals[i]);

    // Continuous start, alternating operand after each result.
    @(negedge clk);
    bin   = 16'd42;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done();
      bin = (bin == 16'd42) ? 16'd7 : 16'd42;
    end
    start = 1'b0;

    // A start pulse while busy must be ignored.
    @(negedge clk);
    bin   = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    bin   = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'd5;
    wait_done();

    // Reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    bin   = 16'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_number", 32'(number), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    convert(16'd4321);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
